// File: rtl/booth_pkg.sv
// Shared constants and types for the Booth multiplier wrapper.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold a step count of w down to zero.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_integration_core_if.sv
// Operand / product bundle between the operand sources and the multiplier wrapper.
interface booth_integration_core_if #(
  parameter int WIDTH = booth_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0]   input1;
  logic [WIDTH-1:0]   input2;
  logic [2*WIDTH-1:0] output1;

  modport master (output input1, output input2, input output1);
  modport slave  (input input1, input input2, output output1);

endinterface

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth datapath: one add/subtract plus arithmetic shift per cycle.
// The accumulator is one bit wider than the operands so that the most negative
// multiplicand can be negated without overflow.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH:0]   acc_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] q_q;
  logic             qm1_q;
  logic [CW-1:0]    cnt_q;

  // Booth recode of {Q[0], q_m1}: add, subtract or pass the accumulator.
  always_comb begin
    sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
  end

  // Load on start, stop on abort, otherwise step while steps remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      m_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      acc_q <= '0;
      m_q   <= {multiplicand[WIDTH-1], multiplicand};
      q_q   <= multiplier;
      qm1_q <= 1'b0;
      cnt_q <= CW'(WIDTH);
    end else if (abort) begin
      cnt_q <= '0;
    end else if (cnt_q != '0) begin
      acc_q <= {sum[WIDTH], sum[WIDTH:1]};
      q_q   <= {sum[0], q_q[WIDTH-1:1]};
      qm1_q <= q_q[0];
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // done flags the cycle whose step is the final one.
  assign done    = (cnt_q == CW'(1));
  assign product = {acc_q[WIDTH-1:0], q_q};

endmodule

// File: rtl/booth_integration_core.sv
// Free-running signed multiplier wrapper: recomputes whenever the operands
// differ from the last latched pair and holds the product on a register.
//
// state | meaning
// IDLE  | result valid (or never computed); watching for an operand change
// RUN   | Booth datapath stepping, one bit per cycle
// DONE  | final step finished; product is written to output1
//
// An operand mismatch is acted on from any state, so a new computation always
// starts on the first edge that sees new operands and the result lands a fixed
// 34 edges (WIDTH=32) after the last change, even if the change interrupts RUN.
module booth_integration_core
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  booth_integration_core_if.slave  bus
);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic               loaded_q;
  logic [2*WIDTH-1:0] out_q;
  logic               mismatch;
  logic               start;
  logic               abort;
  logic               out_we;
  logic               dp_done;
  logic [2*WIDTH-1:0] dp_product;

  assign mismatch = !loaded_q || ({bus.input1, bus.input2} != {opa_q, opb_q});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (mismatch) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = dp_done ? DONE : RUN;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: datapath control and output-register write enable.
  always_comb begin
    start  = mismatch;
    abort  = (state_q == RUN) && mismatch;
    out_we = (state_q == DONE);
  end

  // Latch the operand pair each computation is working on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q    <= '0;
      opb_q    <= '0;
      loaded_q <= 1'b0;
    end else if (mismatch) begin
      opa_q    <= bus.input1;
      opb_q    <= bus.input2;
      loaded_q <= 1'b1;
    end
  end

  // Product register, updated only on DONE so partial values never escape.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_q <= '0;
    else if (out_we) out_q <= dp_product;
  end

  assign bus.output1 = out_q;

  booth_seq_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .multiplicand (bus.input1),
    .multiplier   (bus.input2),
    .done         (dp_done),
    .product      (dp_product)
  );

endmodule

// File: tb/tb_booth_integration_core.sv
// Directed bench for booth_integration_core: product table plus latency,
// abort, DONE-collision and mid-run reset sequences.
module tb_booth_integration_core;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  booth_integration_core_if #(.WIDTH(W)) bif ();

  booth_integration_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after an operand change: output must hold old_v on edges
  // first..33, then show new_v on edge 34.
  task automatic hold_then_new(input logic [2*W-1:0] old_v, input logic [2*W-1:0] new_v,
                               input string nm, input int first);
    bit             ok;
    int             bad_edge;
    logic [2*W-1:0] bad_v;
    ok       = 1'b1;
    bad_edge = 0;
    bad_v    = '0;
    for (int e = first; e <= 33; e++) begin
      tick(1);
      if (ok && bif.output1 !== old_v) begin
        ok       = 1'b0;
        bad_edge = e;
        bad_v    = bif.output1;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_hold: edge %0d got %h expected %h", nm, bad_edge, bad_v, old_v);
    end
    tick(1);
    check({nm, "_new"}, bif.output1, new_v);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{"p5_m5",   32'h00000005, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFE7};
    vecs[1] = '{"m5_m5",   32'hFFFFFFFB, 32'hFFFFFFFB, 64'h0000000000000019};
    vecs[2] = '{"m5_p5",   32'hFFFFFFFB, 32'h00000005, 64'hFFFFFFFFFFFFFFE7};
    vecs[3] = '{"z_m5",    32'h00000000, 32'hFFFFFFFB, 64'h0000000000000000};
    vecs[4] = '{"one_m5",  32'h00000001, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFFB};
    vecs[5] = '{"p8_p6",   32'h00000008, 32'h00000006, 64'h0000000000000030};
    vecs[6] = '{"m12_p6",  32'hFFFFFFF4, 32'h00000006, 64'hFFFFFFFFFFFFFFB8};
    vecs[7] = '{"min_min", 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[8] = '{"max_min", 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
    vecs[9] = '{"max_max", 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};

    // Reset state, then first result after release.
    rst_n      = 1'b0;
    bif.input1 = 32'd3;
    bif.input2 = 32'd7;
    #1;
    check("reset_out", bif.output1, 64'd0);
    #21;
    rst_n = 1'b1;
    hold_then_new(64'd0, 64'd21, "post_reset", 1);

    // Product table, each given ample settling time.
    for (int i = 0; i < 10; i++) begin
      bif.input1 = vecs[i].a;
      bif.input2 = vecs[i].b;
      tick(50);
      check(vecs[i].name, bif.output1, vecs[i].exp);
    end

    // Exact latency: 5x5 -> 8x6.
    bif.input1 = 32'd5;
    bif.input2 = 32'd5;
    tick(50);
    check("lat_base", bif.output1, 64'd25);
    bif.input1 = 32'd8;
    bif.input2 = 32'd6;
    hold_then_new(64'd25, 64'd48, "latency", 1);

    // Stable operands: result held, nothing recomputed.
    tick(100);
    check("stable_hold", bif.output1, 64'd48);

    // Abort: change again 10 edges into a run; intermediate product never shows.
    bif.input1 = 32'hFFFFFFF4;
    bif.input2 = 32'd6;
    tick(10);
    bif.input1 = 32'h7FFFFFFF;
    bif.input2 = 32'h80000000;
    hold_then_new(64'd48, 64'hC000000080000000, "abort", 1);

    // Change landing on the DONE edge: old product still written, then restart.
    bif.input1 = 32'd5;
    bif.input2 = 32'hFFFFFFFB;
    tick(33);
    bif.input1 = 32'd1;
    bif.input2 = 32'hFFFFFFFB;
    tick(1);
    check("collide_done", bif.output1, 64'hFFFFFFFFFFFFFFE7);
    hold_then_new(64'hFFFFFFFFFFFFFFE7, 64'hFFFFFFFFFFFFFFFB, "collide", 2);

    // Asynchronous reset in the middle of a run.
    bif.input1 = 32'hFFFFFFFB;
    bif.input2 = 32'hFFFFFFFB;
    tick(15);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_reset", bif.output1, 64'd0);
    tick(2);
    #3;
    rst_n = 1'b1;
    hold_then_new(64'd0, 64'h19, "rst_rerun", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
